// File: rtl/test_package.sv
// -----------------------------------------------------------------------------
// test_package
// Shared types and default constants for the PWM / sensor-setup monitor.
//   mon_state_t   : monitor FSM state encoding (IDLE, SETUP, MEAS, FAIL)
//   PWM_PERIOD    : default PWM period in clk cycles
//   NEMO_SETUP_TO : default sensor-setup timeout in clk cycles
// -----------------------------------------------------------------------------
package test_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        MEAS  = 2'd2,
        FAIL  = 2'd3
    } mon_state_t;

    localparam int PWM_PERIOD    = 2048;
    localparam int NEMO_SETUP_TO = 500000;

endpackage

// File: rtl/pwm_duty_ch.sv
// -----------------------------------------------------------------------------
// pwm_duty_ch
// Per-channel high-time counter and sticky overlap detector for one
// complementary PWM pair.
//   clk, rst_n    : clock, async active-low reset
//   pwm1, pwm2    : high-side / low-side drive of this pair
//   meas_en       : monitor is measuring this cycle (MEAS and enabled)
//   wrap          : last cycle of the PWM period
//   chk_en        : overlap checking active (any state but IDLE)
//   clr           : clear the sticky overlap flag
//   duty          : last completed period's pwm1 high count
//   overlap_err   : sticky, pwm1 and pwm2 were seen high together
// -----------------------------------------------------------------------------
module pwm_duty_ch #(
    parameter int DUTY_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm1,
    input  logic              pwm2,
    input  logic              meas_en,
    input  logic              wrap,
    input  logic              chk_en,
    input  logic              clr,
    output logic [DUTY_W-1:0] duty,
    output logic              overlap_err
);

    logic [DUTY_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              ovl_q, ovl_d;

    always_comb begin
        hi_cnt_d = '0;
        duty_d   = duty_q;
        if (meas_en) begin
            if (wrap) begin
                // Include this cycle's sample so a 100% period reads PERIOD.
                duty_d = hi_cnt_q + DUTY_W'(pwm1);
            end else begin
                hi_cnt_d = hi_cnt_q + DUTY_W'(pwm1);
            end
        end

        // Clear first so a coincident overlap keeps the flag set.
        ovl_d = ovl_q;
        if (clr)
            ovl_d = 1'b0;
        if (chk_en && pwm1 && pwm2)
            ovl_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_q <= '0;
            duty_q   <= '0;
            ovl_q    <= 1'b0;
        end else begin
            hi_cnt_q <= hi_cnt_d;
            duty_q   <= duty_d;
            ovl_q    <= ovl_d;
        end
    end

    assign duty        = duty_q;
    assign overlap_err = ovl_q;

endmodule

// File: rtl/pwm_setup_monitor.sv
// -----------------------------------------------------------------------------
// pwm_setup_monitor
// Bring-up monitor: waits for the sensor setup-done flag with a timeout, then
// measures per-period pwm1 high time on NUM_CH complementary pairs and flags
// any cycle where a pair is driven high on both sides.
//   clk, rst_n     : clock, async active-low reset
//   en             : level, runs the monitor; low returns it to IDLE
//   clr_err        : pulse, clears setup_ok / setup_timeout / overlap_err
//   setup_done     : level, sensor setup complete
//   pwm1, pwm2     : high-side / low-side PWM per pair
//   state          : current FSM state (mon_state_t)
//   setup_ok       : sticky, setup seen before timeout
//   setup_timeout  : sticky, SETUP_TO cycles elapsed without setup_done
//   overlap_err    : sticky per pair, both sides seen high
//   duty           : last period's high count, channel i at [i*DUTY_W +: DUTY_W]
//   duty_vld       : one-cycle strobe when duty updates
// -----------------------------------------------------------------------------
module pwm_setup_monitor
    import test_package::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PERIOD   = PWM_PERIOD,
    parameter int SETUP_TO = NEMO_SETUP_TO,
    localparam int DUTY_W  = $clog2(PERIOD + 1),
    localparam int TO_W    = $clog2(SETUP_TO + 1),
    localparam int PER_W   = $clog2(PERIOD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr_err,
    input  logic                     setup_done,
    input  logic [NUM_CH-1:0]        pwm1,
    input  logic [NUM_CH-1:0]        pwm2,
    output logic [1:0]               state,
    output logic                     setup_ok,
    output logic                     setup_timeout,
    output logic [NUM_CH-1:0]        overlap_err,
    output logic [NUM_CH*DUTY_W-1:0] duty,
    output logic                     duty_vld
);

    mon_state_t       state_q, state_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic             setup_ok_q, setup_ok_d;
    logic             setup_to_q, setup_to_d;
    logic             duty_vld_q;

    logic meas_en;
    logic wrap;
    logic chk_en;

    assign meas_en = en && (state_q == MEAS);
    assign wrap    = meas_en && (per_cnt_q == PER_W'(PERIOD - 1));
    assign chk_en  = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = '0;
        per_cnt_d  = '0;
        setup_ok_d = setup_ok_q;
        setup_to_d = setup_to_q;

        if (clr_err) begin
            setup_ok_d = 1'b0;
            setup_to_d = 1'b0;
        end

        // Counters default to zero, so dropping en discards any partial
        // setup wait or PWM period.
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = SETUP;
                SETUP: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    // setup_done takes priority over a coincident timeout.
                    if (setup_done) begin
                        setup_ok_d = 1'b1;
                        state_d    = MEAS;
                    end else if (to_cnt_q == TO_W'(SETUP_TO - 1)) begin
                        setup_to_d = 1'b1;
                        state_d    = FAIL;
                    end
                end
                MEAS: per_cnt_d = wrap ? '0 : per_cnt_q + PER_W'(1);
                FAIL: state_d = FAIL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            per_cnt_q  <= '0;
            setup_ok_q <= 1'b0;
            setup_to_q <= 1'b0;
            duty_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            per_cnt_q  <= per_cnt_d;
            setup_ok_q <= setup_ok_d;
            setup_to_q <= setup_to_d;
            duty_vld_q <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_duty_ch #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .pwm1        (pwm1[i]),
            .pwm2        (pwm2[i]),
            .meas_en     (meas_en),
            .wrap        (wrap),
            .chk_en      (chk_en),
            .clr         (clr_err),
            .duty        (duty[i*DUTY_W +: DUTY_W]),
            .overlap_err (overlap_err[i])
        );
    end

    assign state         = state_q;
    assign setup_ok      = setup_ok_q;
    assign setup_timeout = setup_to_q;
    assign duty_vld      = duty_vld_q;

endmodule

// File: tb/tb_pwm_setup_monitor.sv
// -----------------------------------------------------------------------------
// tb_pwm_setup_monitor
// Directed bench for pwm_setup_monitor (NUM_CH=2, PERIOD=16, SETUP_TO=100).
// Expected duty values and the cycle of each duty_vld are queued when a
// period's stimulus is driven and popped when the strobe appears.
// -----------------------------------------------------------------------------
module tb_pwm_setup_monitor;
    import test_package::*;

    localparam int NCH = 2;
    localparam int PER = 16;
    localparam int STO = 100;
    localparam int DW  = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             clr_err = 1'b0;
    logic             setup_done = 1'b0;
    logic [NCH-1:0]   pwm1 = '0;
    logic [NCH-1:0]   pwm2 = '0;
    logic [1:0]       state;
    logic             setup_ok, setup_timeout, duty_vld;
    logic [NCH-1:0]   overlap_err;
    logic [NCH*DW-1:0] duty;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   npass = 0;
    int   ntot  = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    pwm_setup_monitor #(
        .NUM_CH   (NCH),
        .PERIOD   (PER),
        .SETUP_TO (STO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .clr_err       (clr_err),
        .setup_done    (setup_done),
        .pwm1          (pwm1),
        .pwm2          (pwm2),
        .state         (state),
        .setup_ok      (setup_ok),
        .setup_timeout (setup_timeout),
        .overlap_err   (overlap_err),
        .duty          (duty),
        .duty_vld      (duty_vld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    endtask

    // Advance one clock, sample 1ns later, and score any duty strobe.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (duty_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_duty_vld", 32'(duty_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("duty_ch0", 32'(duty[DW-1:0]), 32'(e.d0));
                chk("duty_ch1", 32'(duty[2*DW-1:DW]), 32'(e.d1));
                chk("duty_vld_cycle", 32'(cyc), 32'(e.at));
            end
        end
    endtask

    // mode 0: ch0 high 4/16, ch1 high 12/16; mode 1: ch0 always 1, ch1 always 0.
    task automatic drive(input int mode, input int ph, input bit inj);
        logic [NCH-1:0] p1;
        p1[0] = (mode == 0) ? (ph < 4)  : 1'b1;
        p1[1] = (mode == 0) ? (ph < 12) : 1'b0;
        pwm1 = p1;
        pwm2 = ~p1;
        if (inj) begin
            pwm1[1] = 1'b1;
            pwm2[1] = 1'b1;
        end
    endtask

    // One full period starting at MEAS phase 0; optional overlap injection
    // and clr_err pulse at given phases (-1 = none).
    task automatic run_period(input int mode, input int inj_ph, input int clr_ph);
        int e0, e1;
        e0 = (mode == 0) ? 4 : 16;
        e1 = (mode == 0) ? 12 : 0;
        if (inj_ph >= 0 && (mode != 0 || inj_ph >= 12))
            e1++;
        for (int p = 0; p < PER; p++) begin
            drive(mode, p, p == inj_ph);
            clr_err = (p == clr_ph);
            if (p == PER - 1)
                sb.push_back('{DW'(e0), DW'(e1), cyc + 1});
            tick();
        end
        clr_err = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_setup_ok", 32'(setup_ok), 32'd0);
        chk("rst_timeout", 32'(setup_timeout), 32'd0);
        chk("rst_overlap", 32'(overlap_err), 32'd0);
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_duty_vld", 32'(duty_vld), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'(state), 32'(IDLE));

        // Timeout: exactly STO cycles after SETUP entry
        en = 1'b1;
        tick();
        chk("to_enter_setup", 32'(state), 32'(SETUP));
        repeat (STO - 1) tick();
        chk("to_not_yet", 32'(setup_timeout), 32'd0);
        chk("to_still_setup", 32'(state), 32'(SETUP));
        tick();
        chk("to_raised", 32'(setup_timeout), 32'd1);
        chk("to_state_fail", 32'(state), 32'(FAIL));
        chk("to_setup_ok_low", 32'(setup_ok), 32'd0);
        repeat (5) tick();
        chk("fail_holds", 32'(state), 32'(FAIL));
        en = 1'b0;
        tick();
        chk("fail_to_idle", 32'(state), 32'(IDLE));
        chk("to_sticky", 32'(setup_timeout), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_cleared", 32'(setup_timeout), 32'd0);

        // Setup at SETUP cycle 40, then steady measurement
        en = 1'b1;
        tick();
        chk("ok_enter_setup", 32'(state), 32'(SETUP));
        repeat (40) tick();
        setup_done = 1'b1;
        tick();
        chk("ok_state_meas", 32'(state), 32'(MEAS));
        chk("ok_setup_ok", 32'(setup_ok), 32'd1);
        chk("ok_no_timeout", 32'(setup_timeout), 32'd0);
        repeat (3) run_period(0, -1, -1);
        chk("no_overlap_compl", 32'(overlap_err), 32'd0);

        // Boundary duty 100% / 0%
        run_period(1, -1, -1);

        // Overlap on ch1, sticky, clr vs coincident set, clr alone
        run_period(1, 5, -1);
        chk("ovl_set", 32'(overlap_err), 32'b10);
        run_period(1, -1, -1);
        chk("ovl_sticky", 32'(overlap_err), 32'b10);
        run_period(1, 3, 3);
        chk("ovl_set_wins_clr", 32'(overlap_err), 32'b10);
        run_period(1, -1, 7);
        chk("ovl_cleared", 32'(overlap_err), 32'd0);

        // en dropped at per_cnt=7: partial period discarded
        for (int p = 0; p < 7; p++) begin
            drive(0, p, 1'b0);
            tick();
        end
        drive(0, 7, 1'b0);
        en = 1'b0;
        tick();
        chk("drop_idle", 32'(state), 32'(IDLE));
        pwm1 = '0;
        pwm2 = '0;
        repeat (PER + 4) tick();
        chk("drop_duty0_kept", 32'(duty[DW-1:0]), 32'd16);
        chk("drop_duty1_kept", 32'(duty[2*DW-1:DW]), 32'd0);
        en = 1'b1;
        tick();
        chk("re_setup", 32'(state), 32'(SETUP));
        tick();
        chk("re_meas_1cyc", 32'(state), 32'(MEAS));
        run_period(0, -1, -1);

        // Async reset mid-MEAS
        for (int p = 0; p < 5; p++) begin
            drive(0, p, 1'b0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_state", 32'(state), 32'(IDLE));
        chk("mrst_duty", 32'(duty), 32'd0);
        chk("mrst_setup_ok", 32'(setup_ok), 32'd0);
        chk("mrst_overlap", 32'(overlap_err), 32'd0);
        chk("mrst_duty_vld", 32'(duty_vld), 32'd0);
        en = 1'b0;
        setup_done = 1'b0;
        pwm1 = '0;
        pwm2 = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (PER + 4) tick();
        chk("post_rst_idle", 32'(state), 32'(IDLE));
        chk("post_rst_duty", 32'(duty), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/pwm_setup_monitor.md
Name: pwm_setup_monitor

Overview:
- Synthesizable on-chip monitor for the Knight motor drive and inertial-sensor bring-up.
- Watches a sensor-setup-done flag with a programmable timeout.
- After setup, measures per-period high time on NUM_CH complementary PWM pairs and flags any cycle where a pair is driven high on both sides.
- Sits beside the motor-drive block; its results feed status/telemetry logic or a bench scoreboard.

Parameters:
NUM_CH, 2, number of PWM pairs (pwm1/pwm2) monitored
PERIOD, 2048, PWM period in clk cycles; must be >= 2
SETUP_TO, 500000, max clk cycles allowed in SETUP before timeout; must be >= 1
(localparam) DUTY_W = $clog2(PERIOD+1); TO_W = $clog2(SETUP_TO+1); PER_W = $clog2(PERIOD)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  level; high runs the monitor, low returns it to IDLE
clr_err  in  1  one-cycle pulse; clears sticky flags
setup_done  in  1  level; sensor-setup-complete indication
pwm1  in  NUM_CH  high-side PWM per pair
pwm2  in  NUM_CH  low-side PWM per pair
state  out  2  current FSM state (pkg enum)
setup_ok  out  1  sticky; setup observed before timeout
setup_timeout  out  1  sticky; SETUP_TO reached without setup_done
overlap_err  out  NUM_CH  sticky; pwm1[i] & pwm2[i] seen high together
duty  out  NUM_CH*DUTY_W  last completed period's pwm1 high count; channel i at [i*DUTY_W +: DUTY_W]
duty_vld  out  1  one-cycle strobe when duty updates

Behaviour:
- Reset (async, rst_n low): state=IDLE; all counters, duty, duty_vld, setup_ok, setup_timeout, overlap_err = 0.
- FSM states:
  - IDLE -> SETUP when en=1.
  - SETUP:
    - to_cnt increments each cycle.
    - setup_done==1 (level, sampled) -> setup_ok<=1, go MEAS.
    - Otherwise, when to_cnt==SETUP_TO-1 -> setup_timeout<=1, go FAIL.
    - setup_done and timeout in the same cycle: setup_done wins, no timeout.
    - setup_done already high on entry: MEAS on the next cycle; 1-cycle SETUP latency.
  - MEAS:
    - per_cnt counts 0..PERIOD-1 and wraps.
    - hi_cnt[i] increments each cycle pwm1[i]==1.
    - On the wrap cycle (per_cnt==PERIOD-1): duty[i] <= hi_cnt[i] + pwm1[i] that cycle; hi_cnt[i] cleared; duty_vld=1 on the following cycle.
    - First duty_vld comes exactly PERIOD cycles after MEAS entry.
    - Range is 0..PERIOD inclusive; DUTY_W covers 100% without overflow.
  - FAIL: holds until en=0.
- en=0 in any state: next state IDLE. to_cnt, per_cnt and hi_cnt are cleared; any partial period is discarded with no duty_vld. Sticky flags and last duty are retained.
- Overlap:
  - Checked every cycle in all states except IDLE.
  - overlap_err[i] <= 1 when pwm1[i]&pwm2[i].
  - Both low is legal (dead time); no error.
- clr_err clears setup_ok, setup_timeout and overlap_err. A set condition in the same cycle wins, so the flag stays 1.
- setup_ok and setup_timeout are mutually exclusive within one IDLE->SETUP pass. Re-entering SETUP with stale flags is allowed; clr_err is the only clear.
- Inputs are synchronous to clk; no synchronizers inside.

Decomposition:
- Package test_package (shared): typedef enum logic[1:0] {IDLE, SETUP, MEAS, FAIL} mon_state_t, and default constants PWM_PERIOD=2048, NEMO_SETUP_TO=500000.
- One sub-module, pwm_duty_ch:
  - Inputs: per-channel hi_cnt, overlap sticky, clr, meas_en, wrap.
  - Generated NUM_CH times.
  - Top holds the FSM, to_cnt and per_cnt.

Test Plan:
- Reset mid-MEAS, then release -> all outputs 0, state IDLE, no duty_vld for ≥PERIOD cycles while en=0.
- SETUP_TO=100, en=1, setup_done held 0 -> setup_timeout rises exactly 100 cycles after SETUP entry; state FAIL; setup_ok=0; en=0 -> IDLE.
- setup_done rises at cycle 40 of SETUP; PERIOD=16; pwm1[0] high 4/16 and pwm1[1] high 12/16, pwm2 complementary -> setup_ok=1; duty = {12, 4}; duty_vld pulses every 16 cycles; overlap_err=0.
- Boundary duty with PERIOD=16: pwm1[0] constant 1, pwm1[1] constant 0 -> duty[0]=16, duty[1]=0.
- Force pwm1[1]=pwm2[1]=1 for one cycle in MEAS -> overlap_err=2'b10 and stays set. clr_err coincident with a second overlap -> still 2'b10. clr_err alone -> 0.
- en dropped at per_cnt=7, re-asserted later with setup_done=1 -> no duty_vld from the partial period; next duty_vld exactly PERIOD cycles after re-entering MEAS.
